// File: rtl/hw_accel_frame_ctrl.sv
// ----------------------------------------------------------------------------
// hw_accel_frame_ctrl : frame sequencer for the Sobel/morphology DMA path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hw_accel_frame_ctrl #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int FLUSH_CYCLES = 4,
   parameter int TIMEOUT_W    = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic                 cfg_stop,
   input  logic [15:0]          cfg_num_frames,
   input  logic [TIMEOUT_W-1:0] cfg_timeout,
   input  logic                 in_beat,
   input  logic                 out_beat,
   output logic                 in_enable,
   output logic                 out_enable,
   output logic                 accel_flush,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          frames_done,
   output logic                 err_timeout,
   output logic                 err_overrun
);

   localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
   localparam int FL_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(FRAME_PIXELS);
   localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     in_cnt;
   logic [CNT_W-1:0]     out_cnt;
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic [FL_W-1:0]      flush_cnt;
   logic                 stop_pending;
   logic                 aborted;

   logic                 in_ok;
   logic                 out_ok;
   logic                 in_bad;
   logic                 out_bad;
   logic                 any_beat;
   logic [CNT_W-1:0]     in_nx;
   logic [CNT_W-1:0]     out_nx;
   logic                 in_full;
   logic                 out_full;
   logic                 wd_fire;

   // A beat is only counted inside its open window and below the frame size.
   assign in_ok    = in_beat  && in_enable  && (in_cnt  != PIX_MAX);
   assign out_ok   = out_beat && out_enable && (out_cnt != PIX_MAX);
   assign in_bad   = in_beat  && !in_ok;
   assign out_bad  = out_beat && !out_ok;
   assign any_beat = in_beat || out_beat;
   assign in_nx    = in_cnt  + CNT_W'(in_ok);
   assign out_nx   = out_cnt + CNT_W'(out_ok);
   assign in_full  = (in_nx  == PIX_MAX);
   assign out_full = (out_nx == PIX_MAX);
   assign wd_fire  = (cfg_timeout != '0) && !any_beat &&
                     (wd_cnt == cfg_timeout - TIMEOUT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         in_cnt       <= '0;
         out_cnt      <= '0;
         wd_cnt       <= '0;
         flush_cnt    <= '0;
         stop_pending <= 1'b0;
         aborted      <= 1'b0;
         in_enable    <= 1'b0;
         out_enable   <= 1'b0;
         accel_flush  <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         frames_done  <= '0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (in_bad || out_bad) begin
            err_overrun <= 1'b1;
         end
         if (state != S_IDLE && cfg_stop) begin
            stop_pending <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  in_cnt       <= '0;
                  out_cnt      <= '0;
                  wd_cnt       <= '0;
                  frames_done  <= '0;
                  err_timeout  <= 1'b0;
                  err_overrun  <= 1'b0;
                  stop_pending <= cfg_stop;
                  in_enable    <= 1'b1;
                  out_enable   <= 1'b1;
                  busy         <= 1'b1;
                  state        <= S_RUN;
               end
            end

            S_RUN, S_DRAIN: begin
               in_cnt  <= in_nx;
               out_cnt <= out_nx;
               if (any_beat) begin
                  wd_cnt <= '0;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + TIMEOUT_W'(1);
               end
               // Output completion wins so a simultaneous last beat skips DRAIN.
               if (out_full) begin
                  in_enable   <= 1'b0;
                  out_enable  <= 1'b0;
                  accel_flush <= 1'b1;
                  flush_cnt   <= '0;
                  aborted     <= 1'b0;
                  state       <= S_FLUSH;
               end else if (state == S_RUN && in_full) begin
                  in_enable <= 1'b0;
                  state     <= S_DRAIN;
               end else if (wd_fire) begin
                  err_timeout <= 1'b1;
                  in_enable   <= 1'b0;
                  out_enable  <= 1'b0;
                  accel_flush <= 1'b1;
                  flush_cnt   <= '0;
                  aborted     <= 1'b1;
                  state       <= S_FLUSH;
               end
            end

            S_FLUSH: begin
               if (flush_cnt == FL_LAST) begin
                  accel_flush <= 1'b0;
                  in_cnt      <= '0;
                  out_cnt     <= '0;
                  wd_cnt      <= '0;
                  if (aborted) begin
                     busy         <= 1'b0;
                     stop_pending <= 1'b0;
                     state        <= S_IDLE;
                  end else begin
                     frame_done  <= 1'b1;
                     frames_done <= frames_done + 16'd1;
                     if (stop_pending ||
                         (cfg_num_frames != 16'd0 && frames_done + 16'd1 == cfg_num_frames)) begin
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= S_IDLE;
                     end else begin
                        in_enable  <= 1'b1;
                        out_enable <= 1'b1;
                        state      <= S_RUN;
                     end
                  end
               end else begin
                  flush_cnt <= flush_cnt + FL_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hw_accel_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hw_accel_frame_ctrl : randomized bench for hw_accel_frame_ctrl (4x2 frames)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hw_accel_frame_ctrl;

   localparam int FW     = 4;
   localparam int FH     = 2;
   localparam int FP     = FW * FH;
   localparam int FLC    = 4;
   localparam int TW     = 12;
   localparam int WD_MAX = (1 << TW) - 1;
   localparam int P_IDLE = 0, P_FILL = 1, P_DRAIN = 2, P_FLUSH = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_start = 1'b0;
   logic          cfg_stop = 1'b0;
   logic [15:0]   cfg_num_frames = 16'd0;
   logic [TW-1:0] cfg_timeout = '0;
   logic          in_beat = 1'b0;
   logic          out_beat = 1'b0;
   logic          in_enable, out_enable, accel_flush, busy, frame_done;
   logic [15:0]   frames_done;
   logic          err_timeout, err_overrun;

   int checks = 0;
   int errors = 0;

   // Reference model: pixel tallies, a quiet-cycle tally and a flush countdown.
   int   phase = P_IDLE, in_got = 0, out_got = 0, quiet = 0, flush_left = 0, e_frames = 0;
   bit   abort_run = 0, stop_req = 0;
   logic e_in_en = 0, e_out_en = 0, e_flush = 0, e_busy = 0, e_fd = 0, e_to = 0, e_ov = 0;

   hw_accel_frame_ctrl #(
      .FRAME_WIDTH  (FW),
      .FRAME_HEIGHT (FH),
      .FLUSH_CYCLES (FLC),
      .TIMEOUT_W    (TW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_start      (cfg_start),
      .cfg_stop       (cfg_stop),
      .cfg_num_frames (cfg_num_frames),
      .cfg_timeout    (cfg_timeout),
      .in_beat        (in_beat),
      .out_beat       (out_beat),
      .in_enable      (in_enable),
      .out_enable     (out_enable),
      .accel_flush    (accel_flush),
      .busy           (busy),
      .frame_done     (frame_done),
      .frames_done    (frames_done),
      .err_timeout    (err_timeout),
      .err_overrun    (err_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [22:0] dut_vec();
      return {in_enable, out_enable, accel_flush, busy, frame_done, err_timeout, err_overrun, frames_done};
   endfunction

   function automatic logic [22:0] exp_vec();
      return {e_in_en, e_out_en, e_flush, e_busy, e_fd, e_to, e_ov, 16'(e_frames)};
   endfunction

   task automatic begin_flush(input bit ab);
      phase = P_FLUSH; e_in_en = 0; e_out_en = 0; e_flush = 1; flush_left = FLC; abort_run = ab;
   endtask

   task automatic go_idle();
      phase = P_IDLE; e_busy = 0; stop_req = 0;
   endtask

   task automatic model_update();
      bit ib_bad, ob_bad, any, fire;
      if (rst) begin
         phase = P_IDLE; in_got = 0; out_got = 0; quiet = 0; flush_left = 0; e_frames = 0;
         abort_run = 0; stop_req = 0;
         e_in_en = 0; e_out_en = 0; e_flush = 0; e_busy = 0; e_fd = 0; e_to = 0; e_ov = 0;
         return;
      end
      e_fd   = 0;
      ib_bad = in_beat  && (!e_in_en  || in_got  == FP);
      ob_bad = out_beat && (!e_out_en || out_got == FP);
      any    = in_beat || out_beat;
      fire   = (cfg_timeout != 0) && !any && (quiet == int'(cfg_timeout) - 1);
      if (ib_bad || ob_bad) e_ov = 1;
      if (phase != P_IDLE && cfg_stop) stop_req = 1;
      case (phase)
         P_IDLE: if (cfg_start) begin
            in_got = 0; out_got = 0; quiet = 0; e_frames = 0; e_to = 0; e_ov = 0;
            stop_req = cfg_stop; phase = P_FILL; e_in_en = 1; e_out_en = 1; e_busy = 1;
         end
         P_FILL, P_DRAIN: begin
            if (in_beat && !ib_bad) in_got++;
            if (out_beat && !ob_bad) out_got++;
            quiet = any ? 0 : ((quiet == WD_MAX) ? quiet : quiet + 1);
            if (out_got == FP) begin_flush(0);
            else if (phase == P_FILL && in_got == FP) begin phase = P_DRAIN; e_in_en = 0; end
            else if (fire) begin e_to = 1; begin_flush(1); end
         end
         default: begin
            flush_left--;
            if (flush_left == 0) begin
               e_flush = 0; in_got = 0; out_got = 0; quiet = 0;
               if (abort_run) go_idle();
               else begin
                  e_fd = 1;
                  e_frames = (e_frames + 1) % 65536;
                  if (stop_req || (cfg_num_frames != 0 && e_frames == int'(cfg_num_frames))) go_idle();
                  else begin phase = P_FILL; e_in_en = 1; e_out_en = 1; end
               end
            end
         end
      endcase
   endtask

   task automatic step(input bit ib, input bit ob, input bit st, input bit sp);
      in_beat = ib; out_beat = ob; cfg_start = st; cfg_stop = sp;
      @(posedge clk);
      model_update();
      #1;
      in_beat = 0; out_beat = 0; cfg_start = 0; cfg_stop = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      step(0, 0, 0, 0);
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_vec() !== 23'd0) begin
         errors++; $display("FAIL reset_outputs got %h want %h", dut_vec(), 23'd0);
      end
   endtask

   task automatic test_single_frame();
      int fl, fd;
      do_reset(); cfg_num_frames = 16'd1; cfg_timeout = '0;
      step(0, 0, 1, 0);
      checks++;
      if ({busy, in_enable, out_enable} !== 3'b111) begin
         errors++; $display("FAIL t1_start got %b want 111", {busy, in_enable, out_enable});
      end
      for (int i = 0; i < FP; i++) begin
         repeat ($urandom_range(0, 2)) begin
            step(0, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t1_in_gap got %h want %h", dut_vec(), exp_vec()); end
         end
         step(1, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t1_in got %h want %h", dut_vec(), exp_vec()); end
      end
      checks++;
      if ({in_enable, out_enable} !== 2'b01) begin
         errors++; $display("FAIL t1_window_after_in got %b want 01", {in_enable, out_enable});
      end
      for (int i = 0; i < FP; i++) begin
         repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
         step(0, 1, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t1_out got %h want %h", dut_vec(), exp_vec()); end
      end
      checks++;
      if ({accel_flush, out_enable} !== 2'b10) begin
         errors++; $display("FAIL t1_flush_entry got %b want 10", {accel_flush, out_enable});
      end
      fl = 1; fd = 0;
      repeat (8) begin
         step(0, 0, 0, 0);
         fl += int'(accel_flush); fd += int'(frame_done);
      end
      checks++;
      if (fl !== FLC) begin errors++; $display("FAIL t1_flush_len got %0d want %0d", fl, FLC); end
      checks++;
      if (fd !== 1) begin errors++; $display("FAIL t1_frame_done got %0d want 1", fd); end
      checks++;
      if ({frames_done, busy} !== {16'd1, 1'b0}) begin
         errors++; $display("FAIL t1_final got frames=%0d busy=%b want 1/0", frames_done, busy);
      end
   endtask

   task automatic test_continuous_stop();
      int ins, outs, done, fdc, busy_seen;
      bit stopped;
      ins = 0; outs = 0; done = 0; fdc = 0; busy_seen = 0; stopped = 0;
      do_reset(); cfg_num_frames = 16'd0; cfg_timeout = '0;
      step(0, 0, 1, 0);
      for (int c = 0; c < 600 && !(done == 3 && e_busy == 0); c++) begin
         bit ib, ob, sp;
         ib = (phase == P_FILL) && (ins < FP) && ($urandom_range(0, 1) == 1);
         ob = (phase == P_FILL || phase == P_DRAIN) && (outs < ins) && ($urandom_range(0, 1) == 1);
         sp = (done == 2) && (ins == 3) && !stopped;
         if (sp) stopped = 1;
         step(ib, ob, 0, sp);
         if (ib) ins++;
         if (ob) outs++;
         checks++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t2_cycle got %h want %h", dut_vec(), exp_vec()); end
         if (frame_done === 1'b1) fdc++;
         if (e_fd) begin done++; ins = 0; outs = 0; end
      end
      checks++;
      if (fdc !== 3) begin errors++; $display("FAIL t2_frame_done got %0d want 3", fdc); end
      checks++;
      if ({frames_done, busy} !== {16'd3, 1'b0}) begin
         errors++; $display("FAIL t2_final got frames=%0d busy=%b want 3/0", frames_done, busy);
      end
      repeat (10) begin step(0, 0, 0, 0); busy_seen += int'(busy); end
      checks++;
      if (busy_seen !== 0) begin errors++; $display("FAIL t2_no_fourth_run got %0d want 0", busy_seen); end
   endtask

   task automatic test_timeout();
      int t_fire, fl, fd;
      t_fire = -1; fl = 0; fd = 0;
      do_reset(); cfg_num_frames = 16'd1; cfg_timeout = TW'(16);
      step(0, 0, 1, 0);
      repeat (5) step(1, 0, 0, 0);
      for (int k = 1; k <= 40; k++) begin
         step(0, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t3_cycle got %h want %h", dut_vec(), exp_vec()); end
         if (err_timeout === 1'b1 && t_fire < 0) t_fire = k;
         fl += int'(accel_flush); fd += int'(frame_done);
      end
      checks++;
      if (t_fire !== 16) begin errors++; $display("FAIL t3_fire_cycle got %0d want 16", t_fire); end
      checks++;
      if (fl !== FLC) begin errors++; $display("FAIL t3_flush_len got %0d want %0d", fl, FLC); end
      checks++;
      if (fd !== 0 || busy !== 1'b0 || frames_done !== 16'd0) begin
         errors++; $display("FAIL t3_final got fd=%0d busy=%b frames=%0d want 0/0/0", fd, busy, frames_done);
      end
   endtask

   task automatic test_overrun();
      do_reset(); cfg_num_frames = 16'd1; cfg_timeout = '0;
      step(0, 0, 1, 0);
      repeat (FP) step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      checks++;
      if (err_overrun !== 1'b1) begin errors++; $display("FAIL t4_drain_overrun got %b want 1", err_overrun); end
      for (int i = 0; i < FP + 6; i++) begin
         step(0, (i < FP), 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t4_cycle got %h want %h", dut_vec(), exp_vec()); end
      end
      step(0, 1, 0, 0);
      checks++;
      if ({err_overrun, busy, frames_done} !== {1'b1, 1'b0, 16'd1}) begin
         errors++; $display("FAIL t4_idle_overrun got ov=%b busy=%b frames=%0d want 1/0/1", err_overrun, busy, frames_done);
      end
      step(0, 0, 1, 0);
      checks++;
      if ({err_overrun, busy} !== 2'b01) begin
         errors++; $display("FAIL t4_start_clears got ov=%b busy=%b want 0/1", err_overrun, busy);
      end
   endtask

   task automatic test_back_to_back();
      int fd;
      bit saw_drain;
      fd = 0; saw_drain = 0;
      do_reset(); cfg_num_frames = 16'd1; cfg_timeout = '0;
      step(0, 0, 1, 0);
      for (int i = 0; i < FP; i++) begin
         step(1, 1, 0, 0);
         if (in_enable === 1'b0 && out_enable === 1'b1) saw_drain = 1;
      end
      checks++;
      if ({accel_flush, in_enable, out_enable} !== 3'b100) begin
         errors++; $display("FAIL t5_direct_flush got %b want 100", {accel_flush, in_enable, out_enable});
      end
      repeat (6) begin
         step(0, 0, 0, 0);
         fd += int'(frame_done);
         checks++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL t5_cycle got %h want %h", dut_vec(), exp_vec()); end
      end
      checks++;
      if (saw_drain !== 1'b0 || fd !== 1) begin
         errors++; $display("FAIL t5_summary got drain=%b fd=%0d want 0/1", saw_drain, fd);
      end
   endtask

   task automatic test_reset_mid_drain();
      int fl;
      fl = 0;
      do_reset(); cfg_num_frames = 16'd2; cfg_timeout = '0;
      step(0, 0, 1, 0);
      repeat (FP) step(1, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      checks++;
      if ({in_enable, out_enable, busy} !== 3'b011) begin
         errors++; $display("FAIL t6_in_drain got %b want 011", {in_enable, out_enable, busy});
      end
      rst = 1;
      step(0, 0, 0, 0);
      rst = 0;
      checks++;
      if (dut_vec() !== 23'd0) begin errors++; $display("FAIL t6_reset got %h want 0", dut_vec()); end
      repeat (6) begin step(0, 0, 0, 0); fl += int'(accel_flush) + int'(busy); end
      checks++;
      if (fl !== 0) begin errors++; $display("FAIL t6_quiet_after_reset got %0d want 0", fl); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int hush;
         hush = 0;
         do_reset();
         cfg_num_frames = 16'($urandom_range(1, 3));
         cfg_timeout    = ($urandom_range(0, 1) == 1) ? TW'(0) : TW'($urandom_range(6, 20));
         for (int c = 0; c < 500; c++) begin
            bit ib, ob, st, sp;
            ib = 0; ob = 0;
            if (hush > 0) hush--;
            else if ($urandom_range(0, 39) == 0) hush = $urandom_range(5, 25);
            else begin
               ib = e_in_en  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
               ob = e_out_en ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            end
            st = !e_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            sp = ($urandom_range(0, 149) == 0);
            step(ib, ob, st, sp);
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rand_cycle r=%0d c=%0d got %h want %h", r, c, dut_vec(), exp_vec()); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_continuous_stop();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_reset_mid_drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL global_timeout got no completion want finish before 1ms");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bench time limit reached");
   end

endmodule

`default_nettype wire
